// File: rtl/if_fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, requests from instruction memory,
// parks one response in a hold buffer under decode back-pressure, and honours
// execute redirects. Define IF_PERF_COUNTERS_EN to add stall/flush counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0060,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_read,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction
`ifdef IF_PERF_COUNTERS_EN
   ,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
`endif
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_FULL  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;

   logic [31:0] target_aligned;
   logic [31:0] req_addr_inc;
   logic        out_free;
   logic        unused_target_lsbs;

   assign target_aligned     = {redirect_target[31:2], 2'b00};
   assign unused_target_lsbs = ^redirect_target[1:0];
   assign req_addr_inc       = req_addr_q + 32'd4;
   assign out_free           = !out_valid_q || id_ready;

   // A request is pending in every state except FULL; reset masks it at once.
   assign imem_read      = !rst && (state_q != S_FULL);
   assign imem_address   = req_addr_q;
   assign if_valid       = out_valid_q;
   assign if_pc          = out_pc_q;
   assign if_instruction = out_instr_q;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path through
      // this block leaves one unassigned and infers a latch.
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      out_instr_d = out_instr_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;

      if (out_valid_q && id_ready) begin
         out_valid_d = 1'b0;
         out_pc_d    = 32'd0;
         out_instr_d = NOP_INSTR;
      end

      if (redirect_valid) begin
         pc_d        = target_aligned;
         out_valid_d = 1'b0;
         out_pc_d    = 32'd0;
         out_instr_d = NOP_INSTR;
         case (state_q)
            S_REQ: begin
               if (imem_resp) req_addr_d = target_aligned;
               else           state_d    = S_DRAIN;
            end
            S_FULL: begin
               req_addr_d = target_aligned;
               state_d    = S_REQ;
            end
            S_DRAIN: begin
               if (imem_resp) begin
                  req_addr_d = target_aligned;
                  state_d    = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem_resp) begin
                  pc_d = req_addr_inc;
                  if (out_free) begin
                     out_valid_d = 1'b1;
                     out_pc_d    = req_addr_q;
                     out_instr_d = imem_rdata;
                     req_addr_d  = req_addr_inc;
                  end else begin
                     buf_pc_d    = req_addr_q;
                     buf_instr_d = imem_rdata;
                     state_d     = S_FULL;
                  end
               end
            end
            S_FULL: begin
               if (id_ready) begin
                  out_valid_d = 1'b1;
                  out_pc_d    = buf_pc_q;
                  out_instr_d = buf_instr_q;
                  req_addr_d  = pc_q;
                  state_d     = S_REQ;
               end
            end
            S_DRAIN: begin
               // The abandoned response is swallowed here; fetch resumes at pc.
               if (imem_resp) begin
                  req_addr_d = pc_q;
                  state_d    = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

`ifdef IF_PERF_COUNTERS_EN
   logic stall_inc;
   logic flush_inc;
   assign stall_inc = out_valid_q && !id_ready;
   // In REQ the read is always in flight, so a redirect there discards it.
   assign flush_inc = redirect_valid &&
                      (out_valid_q || state_q == S_FULL || state_q == S_REQ);
`endif

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         req_addr_q  <= RESET_PC;
         out_valid_q <= 1'b0;
         out_pc_q    <= 32'd0;
         out_instr_q <= NOP_INSTR;
`ifdef IF_PERF_COUNTERS_EN
         stall_count <= 32'd0;
         flush_count <= 32'd0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_instr_q <= out_instr_d;
`ifdef IF_PERF_COUNTERS_EN
         if (stall_inc) stall_count <= stall_count + 32'd1;
         if (flush_inc) flush_count <= flush_count + 32'd1;
`endif
      end
   end

   // NOTE: the hold buffer is pure datapath and is left unreset; it is only
   // read in FULL, which is entered solely by writing it.
   always_ff @(posedge clk) begin
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the fetch stream.
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0060;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_read;
   logic [31:0] imem_address;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_resp = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic        id_ready = 1'b0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
`ifdef IF_PERF_COUNTERS_EN
   logic [31:0] stall_count;
   logic [31:0] flush_count;
`endif

   if_fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem_read      (imem_read),
      .imem_address   (imem_address),
      .imem_rdata     (imem_rdata),
      .imem_resp      (imem_resp),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instruction (if_instruction)
`ifdef IF_PERF_COUNTERS_EN
      ,
      .stall_count    (stall_count),
      .flush_count    (flush_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Model: instructions held in the stage, next PC decode must see, next
   // address memory must be asked for, and whether the current read is doomed.
   int          held = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] exp_fetch = RESET_PC;
   bit          killed = 1'b0;
   bit          model_ok = 1'b0;
   int          age = 0;
   int          cur_lat = 1;
   int          lat_mode = 1;

   bit          p_stall = 1'b0;
   bit          p_outst = 1'b0;
   logic [31:0] p_pc, p_instr, p_addr;

   logic        s_read, s_valid;
   logic [31:0] s_addr, s_pc, s_instr;

   task automatic cycle(input bit r, input bit rdy, input bit rv, input logic [31:0] tgt);
      bit resp, accepted, xfer, kill_now;
      @(negedge clk);
      rst = r;
      #1;
      s_read  = imem_read;
      s_addr  = imem_address;
      s_valid = if_valid;
      s_pc    = if_pc;
      s_instr = if_instruction;

      if (r) check("read_in_rst", 32'(s_read), 32'd0);
      if (model_ok) begin
         check("valid", 32'(s_valid), 32'(held > 0));
         if (!s_valid) begin
            check("idle_pc", s_pc, 32'd0);
            check("idle_instr", s_instr, NOP);
         end
         if (!r) check("read_vs_held", 32'(s_read), 32'(held < 2));
         if (p_stall) begin
            check("stall_pc", s_pc, p_pc);
            check("stall_instr", s_instr, p_instr);
         end
         if (p_outst && !r) check("addr_stable", s_addr, p_addr);
         if (s_read) check("addr_align", 32'(s_addr[1:0]), 32'd0);
      end

      resp = 1'b0;
      if (r) begin
         resp = ($urandom_range(0, 1) == 1);
      end else if (s_read) begin
         if (age == 0) cur_lat = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 3));
         age++;
         if (age >= cur_lat) begin
            resp = 1'b1;
            age  = 0;
         end
      end else begin
         age = 0;
      end
      imem_resp       = resp;
      imem_rdata      = resp ? mem_word(s_addr) : $urandom;
      id_ready        = rdy;
      redirect_valid  = rv;
      redirect_target = tgt;

      p_stall = model_ok && !r && s_valid && !rdy && !rv;
      p_outst = !r && s_read && !resp;
      p_pc    = s_pc;
      p_instr = s_instr;
      p_addr  = s_addr;

      if (r) begin
         held      = 0;
         exp_pc    = RESET_PC;
         exp_fetch = RESET_PC;
         killed    = 1'b0;
         age       = 0;
         model_ok  = 1'b1;
      end else if (model_ok) begin
         xfer = s_valid && rdy && !rv;
         if (xfer) begin
            check("xfer_pc", s_pc, exp_pc);
            check("xfer_instr", s_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end
         kill_now = killed || (rv && s_read);
         accepted = resp && !kill_now;
         if (accepted) begin
            check("fetch_addr", s_addr, exp_fetch);
            exp_fetch = s_addr + 32'd4;
         end
         killed = resp ? 1'b0 : kill_now;
         if (rv) begin
            held      = 0;
            exp_pc    = {tgt[31:2], 2'b00};
            exp_fetch = {tgt[31:2], 2'b00};
         end else begin
            held = held + int'(accepted) - int'(xfer);
         end
      end
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic wait_valid(input string tag, input logic [31:0] want_pc);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 32'd0);
         if (s_valid) found = 1'b1;
      end
      check({tag, "_seen"}, 32'(found), 32'd1);
      check({tag, "_pc"}, s_pc, want_pc);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired @%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Back-to-back fetch with a 1-cycle memory.
      lat_mode = 1;
      do_reset(3);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p1_read", 32'(s_read), 32'd1);
      check("p1_addr0", s_addr, 32'h60);
      check("p1_valid0", 32'(s_valid), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p1_addr1", s_addr, 32'h64);
      check("p1_pc0", s_pc, 32'h60);
      check("p1_instr0", s_instr, mem_word(32'h60));
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p1_addr2", s_addr, 32'h68);
      check("p1_pc1", s_pc, 32'h64);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p1_pc2", s_pc, 32'h68);
      check("p1_instr2", s_instr, mem_word(32'h68));

      // Decode stalls for five cycles after the first instruction.
      do_reset(2);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 32'd0);
         if (i >= 2) begin
            check("p2_full_read", 32'(s_read), 32'd0);
            check("p2_hold_pc", s_pc, 32'h60);
         end
      end
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p2_release_pc", s_pc, 32'h60);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p2_buf_pc", s_pc, 32'h64);
      check("p2_next_read", 32'(s_read), 32'd1);
      check("p2_next_addr", s_addr, 32'h68);

      // Redirect while a 3-cycle read is outstanding.
      lat_mode = 3;
      do_reset(2);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 1'b1, 32'h200);
      check("p3_redir_addr", s_addr, 32'h64);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p3_drain_addr0", s_addr, 32'h64);
      check("p3_flush_valid", 32'(s_valid), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p3_drain_addr1", s_addr, 32'h64);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p3_target_addr", s_addr, 32'h200);
      wait_valid("p3_target", 32'h200);

      // Misaligned redirect while the hold buffer is occupied.
      lat_mode = 1;
      do_reset(2);
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 32'h103);
      check("p4_full_read", 32'(s_read), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p4_drop_valid", 32'(s_valid), 32'd0);
      check("p4_addr", s_addr, 32'h100);
      wait_valid("p4_target", 32'h100);

      // Fetch address wraps past the top of memory.
      cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p5_top_addr", s_addr, 32'hFFFF_FFFC);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p5_wrap_addr", s_addr, 32'h0000_0000);
      check("p5_top_pc", s_pc, 32'hFFFF_FFFC);

      // Reset lands on an in-flight request.
      lat_mode = 3;
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("p6_rst_valid", 32'(s_valid), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("p6_refetch_read", 32'(s_read), 32'd1);
      check("p6_refetch_addr", s_addr, RESET_PC);
      check("p6_refetch_valid", 32'(s_valid), 32'd0);
`ifdef IF_PERF_COUNTERS_EN
      check("p6_stall_count", stall_count, 32'd0);
      check("p6_flush_count", flush_count, 32'd0);
`endif

      // Random traffic: variable latency, back-pressure, redirects, resets.
      lat_mode = 0;
      for (int i = 0; i < 3000; i++) begin
         bit          r, rdy, rv;
         logic [31:0] tgt;
         r   = ($urandom_range(0, 199) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 19) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom);
         cycle(r, rdy, rv, tgt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction fetch stage for the pipelined RV32I core. It sits directly upstream of decode/control-word generation and owns the PC register. It issues reads to the instruction-memory port, absorbs decode back-pressure with a one-entry hold buffer, and applies taken-branch/jump redirects from execute. It presents one `{pc, instruction}` pair per handshake to decode.

## Interface
- `RESET_PC`, default 32'h00000060: fetch address after reset.
- `NOP_INSTR`, default 32'h00000013 (`addi x0,x0,0`): value on `if_instruction` whenever no valid instruction is held.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_read` out 1: read request; held high until `imem_resp`.
- `imem_address` out 32: request address; stable while `imem_read`=1; bits [1:0] always 0.
- `imem_rdata` in 32: instruction word; valid only in the `imem_resp` cycle.
- `imem_resp` in 1: one-cycle completion pulse.
- `redirect_valid` in 1: execute redirects fetch (taken branch, jal, jalr).
- `redirect_target` in 32: new PC; bits [1:0] are ignored and treated as 0.
- `id_ready` in 1: decode accepts this cycle.
- `if_valid` out 1: `if_pc`/`if_instruction` hold a valid instruction.
- `if_pc` out 32: PC of the presented instruction.
- `if_instruction` out 32: presented instruction.
- `stall_count`, `flush_count` out 32 each: present only with `IF_PERF_COUNTERS_EN` (see Configuration).

## Operation
- Internal registers:
  - `pc`: next address to fetch.
  - `req_addr`: drives `imem_address`.
  - Output register: `if_valid`, `if_pc`, `if_instruction`.
  - Hold buffer: `buf_pc`, `buf_instr`.
  - FSM state.
- Handshake rules:
  - The output register is free when `!if_valid || id_ready`.
  - An instruction is transferred when `if_valid && id_ready`.
- FSM states and transitions:
  - **REQ**
    - Drives `imem_read`=1, `imem_address`=`req_addr`.
    - On `imem_resp` with the output register free: load output `{1, req_addr, imem_rdata}`, set `pc`/`req_addr` ← `req_addr`+4, stay REQ.
    - On `imem_resp` with the output register not free: capture `{req_addr, imem_rdata}` in the hold buffer, set `pc` ← `req_addr`+4, go to FULL.
  - **FULL**
    - Drives `imem_read`=0.
    - On `id_ready`: output ← hold buffer, `req_addr` ← `pc`, go to REQ.
  - **DRAIN**
    - Drives `imem_read`=1 at the old `req_addr`. This is required because the memory protocol forbids abandoning a request.
    - On `imem_resp`: discard `imem_rdata`, `req_addr` ← `pc`, go to REQ.
- Redirect (`redirect_valid`=1) overrides everything else in that cycle:
  - `pc` ← {`target`[31:2], 2'b00}.
  - Next-cycle `if_valid`=0; the hold buffer is discarded; `id_ready` is ignored.
  - In REQ without `imem_resp`: go to DRAIN.
  - In REQ with `imem_resp`: discard the response, `req_addr` ← target, go to REQ.
  - In FULL: `req_addr` ← target, go to REQ.
  - In DRAIN without `imem_resp`: update `pc` only, stay DRAIN. The last redirect wins.
  - In DRAIN with `imem_resp`: `req_addr` ← target, go to REQ.
- Arithmetic: PC increment is modulo 2^32; 32'hFFFFFFFC + 4 = 32'h00000000.
- When `if_valid`=0, `if_instruction`=`NOP_INSTR` and `if_pc`=0.

## Timing
- Reset values, in and after any `rst` cycle:
  - FSM state REQ; `pc` = `req_addr` = `RESET_PC`.
  - Outputs: `imem_read`=0 while `rst`=1, `if_valid`=0, `if_pc`=0, `if_instruction`=`NOP_INSTR`.
  - Counters cleared to 0.
- First request: `imem_read`=1 with `imem_address`=`RESET_PC` in the first cycle after `rst` deasserts.
- Reset asserted mid-request takes effect immediately. The request is dropped, and any later `imem_resp` arriving during reset is ignored.
- Latency:
  - `imem_resp` in cycle N → `if_valid`=1 with that instruction in cycle N+1.
  - The next request address appears in cycle N+1 with no idle cycle, unless the stage enters FULL.
- Decode stall: `if_valid`, `if_pc` and `if_instruction` stay stable while `id_ready`=0.
- At most two instructions are held (output register plus hold buffer). No request is issued while in FULL.
- Redirect in cycle N: `if_valid`=0 in N+1.
  - The first target request starts in N+1 when no response is outstanding.
  - Otherwise it starts the cycle after the draining `imem_resp`.

## Configuration
- `IF_PERF_COUNTERS_EN` defined:
  - Adds outputs `stall_count` and `flush_count`.
  - `stall_count` increments each cycle with `if_valid && !id_ready`.
  - `flush_count` increments each redirect cycle that discards a valid output, a buffered instruction, or an outstanding request.
  - Both counters wrap at 2^32 and reset to 0.
- `IF_PERF_COUNTERS_EN` undefined: the ports and registers are absent; all other behaviour is identical.

## Test plan
- Reset release, 1-cycle memory, `id_ready`=1:
  - Required: addresses 0x60, 0x64, 0x68 issued back-to-back.
  - Required: `if_pc` sequence 0x60/0x64/0x68 with the matching `imem_rdata` words, each 1 cycle after its `imem_resp`.
- `id_ready`=0 for 5 cycles after the first instruction:
  - Required: the second response is buffered and `imem_read`=0 while in FULL.
  - Required: outputs stay at pc 0x60.
  - Required: on `id_ready`=1, pc 0x64 is presented, then a fetch of 0x68 is issued.
- Redirect to 0x200 while a request to 0x64 is outstanding (3-cycle memory):
  - Required: `imem_address` stays 0x64 until `imem_resp`, and that data is never presented.
  - Required: next request is 0x200; `if_pc`=0x200 is presented next.
- Redirect to 0x103 (misaligned) in FULL state:
  - Required: the buffered instruction is dropped and `if_valid`=0 the next cycle.
  - Required: `imem_address`=0x100.
- Fetch from 0xFFFFFFFC:
  - Required: next `imem_address`=0x00000000.
- Assert `rst` mid-request, then deassert:
  - Required: `imem_read`=0 and `if_valid`=0 during reset.
  - Required: refetch at 0x60.
  - Required, with `IF_PERF_COUNTERS_EN`: `stall_count` and `flush_count` read 0.
